// File: rtl/full_adder_reg_if.sv
// Operand/result bundle for the registered full adder.
// master drives a/b/rin/in_valid and sees z/rout/ovf/out_valid; slave is the adder.
interface full_adder_reg_if #(
    parameter int WIDTH = 1
) ();
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             rin;
    logic             in_valid;
    logic [WIDTH-1:0] z;
    logic             rout;
    logic             ovf;
    logic             out_valid;

    modport master (
        output a, b, rin, in_valid,
        input  z, rout, ovf, out_valid
    );

    modport slave (
        input  a, b, rin, in_valid,
        output z, rout, ovf, out_valid
    );
endinterface

// File: rtl/full_adder_reg.sv
// Registered ripple-carry adder: {rout,z} = a + b + rin, 1-cycle latency.
// Ports: clk, rst_n (async low), io.slave (a,b,rin,in_valid -> z,rout,ovf,out_valid).
module full_adder_reg #(
    parameter int WIDTH      = 1,
    parameter bit SIGNED_OVF = 1'b1
) (
    input logic             clk,
    input logic             rst_n,
    full_adder_reg_if.slave io
);
    logic [WIDTH-1:0] s_n;
    logic             cy;
    logic             c_msb_in;
    logic             ovf_n;

    // cy walks the chain bit by bit; c_msb_in ends as the carry into the MSB
    // (rin itself when WIDTH is 1).
    always_comb begin
        cy       = io.rin;
        c_msb_in = io.rin;
        s_n      = '0;
        for (int i = 0; i < WIDTH; i++) begin
            c_msb_in = cy;
            s_n[i]   = io.a[i] ^ io.b[i] ^ cy;
            cy       = (io.a[i] & io.b[i])
                     | (io.a[i] & cy)
                     | (io.b[i] & cy);
        end
    end

    assign ovf_n = SIGNED_OVF & (cy ^ c_msb_in);

    // Results are loaded only on valid input and held otherwise, so idle
    // (possibly unknown) operands never reach the outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            io.out_valid <= 1'b0;
            io.z         <= '0;
            io.rout      <= 1'b0;
            io.ovf       <= 1'b0;
        end else begin
            io.out_valid <= io.in_valid;
            if (io.in_valid) begin
                io.z    <= s_n;
                io.rout <= cy;
                io.ovf  <= ovf_n;
            end
        end
    end
endmodule

// File: tb/tb_full_adder_reg.sv
// Scoreboard bench for full_adder_reg at WIDTH=1, WIDTH=8, and WIDTH=8 without ovf.
// Expected results come from integer arithmetic on the issued operands.
module tb_full_adder_reg;
    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    full_adder_reg_if #(.WIDTH(1)) i1 ();
    full_adder_reg_if #(.WIDTH(8)) i8 ();
    full_adder_reg_if #(.WIDTH(8)) in8 ();

    full_adder_reg #(.WIDTH(1), .SIGNED_OVF(1'b1)) u1 (
        .clk(clk), .rst_n(rst_n), .io(i1));
    full_adder_reg #(.WIDTH(8), .SIGNED_OVF(1'b1)) u8 (
        .clk(clk), .rst_n(rst_n), .io(i8));
    full_adder_reg #(.WIDTH(8), .SIGNED_OVF(1'b0)) un8 (
        .clk(clk), .rst_n(rst_n), .io(in8));

    int n_chk  = 0;
    int n_pass = 0;

    logic [65:0] q [3][$];
    logic [65:0] held [3];
    logic        pend [3];

    task automatic chk(input string nm, input logic [65:0] act,
                       input logic [65:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h want %h", nm, act, exp);
    endtask

    // Returns {ovf, carry, z}: unsigned sum for z/carry, signed range test for ovf.
    function automatic logic [65:0] model(input int w, input logic sov,
                                          input logic [63:0] a,
                                          input logic [63:0] b,
                                          input logic rin);
        logic [64:0] s;
        logic [63:0] mask;
        longint sa, sb, ss, lo, hi;
        logic o;
        s    = {1'b0, a} + {1'b0, b} + 65'(rin);
        mask = (64'd1 << w) - 64'd1;
        sa   = longint'(a);
        sb   = longint'(b);
        if (a[w-1]) sa = sa - (longint'(1) << w);
        if (b[w-1]) sb = sb - (longint'(1) << w);
        ss = sa + sb + longint'(rin);
        lo = -(longint'(1) << (w - 1));
        hi = (longint'(1) << (w - 1)) - 1;
        o  = sov && ((ss < lo) || (ss > hi));
        return {o, s[w], s[63:0] & mask};
    endfunction

    task automatic mon(input int id, input string nm, input logic vld,
                       input logic ro, input logic ov, input logic [63:0] zz);
        chk({nm, ".out_valid"}, 66'(vld), 66'(pend[id]));
        if (vld) begin
            if (q[id].size() == 0) begin
                n_chk++;
                $display("FAIL %s.extra: got result with empty queue want none", nm);
            end else begin
                held[id] = q[id].pop_front();
            end
        end
        chk({nm, ".data"}, {ov, ro, zz}, held[id]);
    endtask

    always @(posedge clk) begin
        if (rst_n && i1.in_valid)
            q[0].push_back(model(1, 1'b1, 64'(i1.a), 64'(i1.b), i1.rin));
        if (rst_n && i8.in_valid)
            q[1].push_back(model(8, 1'b1, 64'(i8.a), 64'(i8.b), i8.rin));
        if (rst_n && in8.in_valid)
            q[2].push_back(model(8, 1'b0, 64'(in8.a), 64'(in8.b), in8.rin));
        pend[0] = rst_n && i1.in_valid;
        pend[1] = rst_n && i8.in_valid;
        pend[2] = rst_n && in8.in_valid;
    end

    always @(negedge rst_n) begin
        for (int k = 0; k < 3; k++) begin
            q[k].delete();
            pend[k] = 1'b0;
            held[k] = '0;
        end
    end

    bit mon_en = 1'b0;

    always @(negedge clk) begin
        if (mon_en) begin
            mon(0, "w1", i1.out_valid, i1.rout, i1.ovf, 64'(i1.z));
            mon(1, "w8", i8.out_valid, i8.rout, i8.ovf, 64'(i8.z));
            mon(2, "w8n", in8.out_valid, in8.rout, in8.ovf, 64'(in8.z));
        end
    end

    task automatic step1(input logic a, input logic b, input logic rin,
                         input logic v);
        @(posedge clk);
        #1;
        i1.a = a; i1.b = b; i1.rin = rin; i1.in_valid = v;
    endtask

    task automatic step8(input logic [7:0] a, input logic [7:0] b,
                         input logic rin, input logic v);
        @(posedge clk);
        #1;
        i8.a = a; i8.b = b; i8.rin = rin; i8.in_valid = v;
    endtask

    task automatic step8n(input logic [7:0] a, input logic [7:0] b,
                          input logic rin, input logic v);
        @(posedge clk);
        #1;
        in8.a = a; in8.b = b; in8.rin = rin; in8.in_valid = v;
    endtask

    initial begin
        for (int k = 0; k < 3; k++) begin
            pend[k] = 1'b0;
            held[k] = '0;
        end
        rst_n = 1'b0;
        i1.a = '0;  i1.b = '0;  i1.rin = 1'b0;  i1.in_valid = 1'b0;
        i8.a = '0;  i8.b = '0;  i8.rin = 1'b0;  i8.in_valid = 1'b0;
        in8.a = '0; in8.b = '0; in8.rin = 1'b0; in8.in_valid = 1'b0;

        repeat (2) @(posedge clk);
        #2;
        chk("reset.w1", {i1.out_valid, i1.ovf, i1.rout, 63'(i1.z)}, '0);
        chk("reset.w8", {i8.out_valid, i8.ovf, i8.rout, 63'(i8.z)}, '0);
        mon_en = 1'b1;
        #1 rst_n = 1'b1;

        // WIDTH=1 exhaustive: {a,b,rin} = 0..7
        for (int k = 0; k < 8; k++) begin
            logic [2:0] v;
            v = 3'(k);
            step1(v[2], v[1], v[0], 1'b1);
        end
        step1(1'b0, 1'b0, 1'b0, 1'b0);

        // Reset while a result with z=1, rout=1 is presented
        step1(1'b1, 1'b1, 1'b1, 1'b1);
        step1(1'b0, 1'b0, 1'b0, 1'b0);
        #2;
        chk("rst.pre", {i1.out_valid, i1.rout, 64'(i1.z)}, {1'b1, 1'b1, 64'd1});
        rst_n = 1'b0;
        #1;
        chk("rst.async", {i1.out_valid, i1.ovf, i1.rout, 63'(i1.z)}, '0);
        @(posedge clk);
        #3 rst_n = 1'b1;
        step1(1'b0, 1'b0, 1'b0, 1'b0);
        step1(1'b0, 1'b0, 1'b0, 1'b0);
        step1(1'b0, 1'b1, 1'b1, 1'b1);

        // Hold: 1+1 then idle cycles with toggling operands
        step1(1'b1, 1'b1, 1'b0, 1'b1);
        for (int k = 0; k < 3; k++)
            step1(1'($urandom), 1'($urandom), 1'($urandom), 1'b0);
        #2;
        chk("hold.w1", {i1.out_valid, i1.rout, 64'(i1.z)}, {1'b0, 1'b1, 64'd0});

        // WIDTH=8 carry ripple and signed overflow
        step8(8'hFF, 8'h00, 1'b1, 1'b1);
        step8(8'h7F, 8'h01, 1'b0, 1'b1);
        step8(8'hFF, 8'hFF, 1'b1, 1'b1);
        step8(8'h00, 8'h00, 1'b0, 1'b1);
        step8(8'h00, 8'h00, 1'b0, 1'b0);
        #2;
        chk("w8.zero", {i8.ovf, i8.rout, 64'(i8.z)}, 66'd0);

        // WIDTH=8 random back-to-back
        for (int k = 0; k < 1000; k++)
            step8(8'($urandom), 8'($urandom), 1'($urandom), 1'b1);
        step8(8'h00, 8'h00, 1'b0, 1'b0);

        // No-overflow build
        step8n(8'h80, 8'h80, 1'b0, 1'b1);
        step8n(8'h00, 8'h00, 1'b0, 1'b0);
        #2;
        chk("w8n.80_80", {in8.ovf, in8.rout, 64'(in8.z)}, {1'b0, 1'b1, 64'd0});
        for (int k = 0; k < 50; k++)
            step8n(8'($urandom), 8'($urandom), 1'($urandom), 1'b1);
        step8n(8'h00, 8'h00, 1'b0, 1'b0);

        repeat (3) @(posedge clk);
        #2;
        for (int k = 0; k < 3; k++)
            chk("drain", 66'(q[k].size()), 66'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/full_adder_reg.md
Name: full_adder_reg

Overview:
- Registered ripple-carry full adder: adds operands a, b and carry-in rin, producing sum z and carry-out rout.
- Width is parameterisable. At WIDTH=1 it is the classic 1-bit full-adder cell with the port order (rout, z, rin, a, b).
- Outputs are registered on the single clock with a valid qualifier, so the block drops into pipelined datapaths as a leaf arithmetic cell.

Parameters:
- WIDTH, 1, operand and sum width in bits (legal: 1..64).
- SIGNED_OVF, 1, when 1 the ovf output reports two's-complement overflow; when 0 ovf is tied to 0.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- rout  output  1  registered carry-out of the MSB.
- z  output  WIDTH  registered sum.
- rin  input  1  carry-in to the LSB.
- a  input  WIDTH  operand A, unsigned bit vector.
- b  input  WIDTH  operand B, unsigned bit vector.
- in_valid  input  1  operands and rin are valid this cycle.
- out_valid  output  1  rout/z/ovf hold a result computed from a valid input.
- ovf  output  1  registered signed overflow, i.e. carry into MSB XOR carry out of MSB.

Behaviour:
- Reset: while rst_n=0, rout=0, z=0, out_valid=0 and ovf=0, asynchronously and immediately. Release is synchronous to the next clk edge.
- Per-bit logic, ripple from bit 0:
  - s[i] = a[i] ^ b[i] ^ c[i]
  - c[i+1] = (a[i]&b[i]) | (a[i]&c[i]) | (b[i]&c[i])
  - c[0] = rin
- Result: {rout_next, z_next} = a + b + rin, computed in WIDTH+1 bits with no truncation loss. rout_next = c[WIDTH].
- ovf_next = c[WIDTH] ^ c[WIDTH-1] when SIGNED_OVF=1; 0 otherwise. For WIDTH=1, c[0]=rin is used as the carry into the MSB.
- Latency: exactly 1 clock. At the rising edge where in_valid=1, z/rout/ovf load the result and out_valid is 1 on the following cycle.
- Cycle with in_valid=0: out_valid deasserts next edge, and z/rout/ovf hold their previous values. Do not clear them, so a downstream stage may sample late.
- Back-to-back valid inputs give one result per cycle. There is no backpressure and no ready signal.
- Inputs carry no internal state beyond the output registers. X on inputs while in_valid=0 must not propagate to outputs.
- Reset asserted mid-stream discards any in-flight result. The first valid input after release produces out_valid one cycle later.
- Boundaries:
  - All-ones a, all-ones b, rin=1 gives z = all-ones, rout=1.
  - All-zero inputs give z=0, rout=0.
  - rin=1 with a=all-ones, b=0 gives full ripple: z=0, rout=1.

Test Plan:
- WIDTH=1 exhaustive: drive {a,b,rin} = 0..7 with in_valid=1, one per cycle. Each result one cycle later must be (rout,z) = 00,01,01,10,01,10,10,11.
- Reset: assert rst_n=0 asynchronously between clock edges while out_valid=1, z=1 and rout=1. All outputs must go to 0 immediately, and out_valid must stay 0 until one cycle after the first post-reset valid input.
- Hold: valid input a=1,b=1,rin=0 (WIDTH=1), then in_valid=0 for 3 cycles with toggling a/b. Required: z=0 and rout=1 held throughout, and out_valid=0 after the first idle cycle.
- WIDTH=8 carry ripple: a=8'hFF, b=8'h00, rin=1 gives z=8'h00, rout=1, ovf=0. Then a=8'h7F, b=8'h01, rin=0 gives z=8'h80, rout=0, ovf=1.
- WIDTH=8 random: 1000 back-to-back random {a,b,rin} with in_valid=1. Each {rout,z} must equal a+b+rin in 9 bits, one cycle later, with no dropped or duplicated results.
- SIGNED_OVF=0: a=8'h80, b=8'h80, rin=0 gives z=8'h00, rout=1, ovf=0.
